hazard_fwd_unit: RTL

Forwarding and load-use hazard controller for the 5-stage pipeline; it drives the operand-forward selects consumed by the EX stage. It tracks destination-register records for the instructions in EX, MEM and WB internally. From these it registers `ALU_SrcA_fwd`/`ALU_SrcB_fwd` so they are valid for the whole EX cycle of the consuming instruction. It also raises a one-cycle stall for load-use dependencies, inserts bubbles on stall or branch flush, and counts stall cycles.

---
 rtl/hazard_fwd_if.sv | 44 ++++
 rtl/hazard_fwd_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/hazard_fwd_if.sv
// ID-side bundle for the forwarding / load-use hazard controller.
// The ID stage presents its decoded operand and destination fields every
// cycle; there is no valid/ready flow control. id_valid qualifies the
// instruction. stall is the back-pressure reply, meaning "this ID instruction
// was not accepted this edge; present it again". id_ex_bubble tells ID/EX to
// load a NOP this edge.
interface hazard_fwd_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic             ex_flush;
    logic [1:0]       ALU_SrcA_fwd;
    logic [1:0]       ALU_SrcB_fwd;
    logic             stall;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_count;
    // Debug view of the EX/MEM/WB records: {dest, regwrite, memread}
    logic [6:0]       dbg_ex_rec;
    logic [6:0]       dbg_mem_rec;
    logic [6:0]       dbg_wb_rec;

    // Pipeline side: drives the ID fields and consumes the controls
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_regwrite, id_memread, ex_flush,
        input  ALU_SrcA_fwd, ALU_SrcB_fwd, stall, id_ex_bubble, stall_count,
               dbg_ex_rec, dbg_mem_rec, dbg_wb_rec
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_regwrite, id_memread, ex_flush,
        output ALU_SrcA_fwd, ALU_SrcB_fwd, stall, id_ex_bubble, stall_count,
               dbg_ex_rec, dbg_mem_rec, dbg_wb_rec
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// It tracks destination records for the instructions in EX, MEM and WB and
// registers the operand-forward selects used during the consumer's EX
// cycle. It also raises a one-cycle load-use stall, inserts bubbles on stall
// or flush, and keeps a saturating count of stall cycles.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_fwd_if.slave bus
);

    typedef struct packed {
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } rec_t;

    // Forward select encoding as seen by the EX operand muxes
    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rec_t             ex_rec;
    rec_t             mem_rec;
    rec_t             wb_rec;
    rec_t             id_rec;
    logic             stall_int;
    logic             bubble_int;
    logic [1:0]       sel_a_next;
    logic [1:0]       sel_b_next;
    logic [1:0]       sel_a_q;
    logic [1:0]       sel_b_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // A record matches only if it writes a non-zero register equal to x
    function automatic logic rec_match(input rec_t r, input logic [4:0] x);
        return r.regwrite && (r.dest != 5'd0) && (r.dest == x);
    endfunction

    // Stall, bubble and next forward selects from the pre-edge records
    always_comb begin
        stall_int  = 1'b0;
        bubble_int = 1'b0;
        sel_a_next = SEL_REG;
        sel_b_next = SEL_REG;
        id_rec     = '{dest: bus.id_dest, regwrite: bus.id_regwrite,
                       memread: bus.id_memread};

        // Flush outranks the load-use stall; reset also suppresses it so a
        // stale load record cannot stall during the reset cycle.
        stall_int = !reset && bus.id_valid && !bus.ex_flush && ex_rec.memread &&
                    ((bus.id_uses_rs && rec_match(ex_rec, bus.id_rs)) ||
                     (bus.id_uses_rt && rec_match(ex_rec, bus.id_rt)));

        bubble_int = stall_int || bus.ex_flush || !bus.id_valid;

        // Nearest producer wins: EX beats MEM. WB is not forwarded because
        // the register file is write-first.
        if (bus.id_uses_rs && rec_match(ex_rec, bus.id_rs)) begin
            sel_a_next = SEL_MEM;
        end else if (bus.id_uses_rs && rec_match(mem_rec, bus.id_rs)) begin
            sel_a_next = SEL_WB;
        end

        if (bus.id_uses_rt && rec_match(ex_rec, bus.id_rt)) begin
            sel_b_next = SEL_MEM;
        end else if (bus.id_uses_rt && rec_match(mem_rec, bus.id_rt)) begin
            sel_b_next = SEL_WB;
        end

        // A bubble entering EX never forwards anything
        if (bubble_int) begin
            sel_a_next = SEL_REG;
            sel_b_next = SEL_REG;
        end
    end

    // Record pipeline, registered selects and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rec      <= '0;
            mem_rec     <= '0;
            wb_rec      <= '0;
            sel_a_q     <= SEL_REG;
            sel_b_q     <= SEL_REG;
            stall_cnt_q <= '0;
        end else begin
            // Records always advance; a stalled ID instruction is
            // replaced by a bubble in EX, never frozen in place.
            mem_rec <= ex_rec;
            wb_rec  <= mem_rec;
            ex_rec  <= bubble_int ? rec_t'('0) : id_rec;
            sel_a_q <= sel_a_next;
            sel_b_q <= sel_b_next;
            if (stall_int && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall        = stall_int;
    assign bus.id_ex_bubble = bubble_int;
    assign bus.ALU_SrcA_fwd = sel_a_q;
    assign bus.ALU_SrcB_fwd = sel_b_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.dbg_ex_rec   = ex_rec;
    assign bus.dbg_mem_rec  = mem_rec;
    assign bus.dbg_wb_rec   = wb_rec;

endmodule
